uart_transceiver_param: RTL and testbench

- Parametrised full-duplex UART: one TX engine and one RX engine sharing one clock domain.
- Replaces the fixed 8-bit TX/RX pair. Adds:
  - configurable data width, parity mode, stop bits and bit period;
  - ready/valid TX handshake;
  - RX input synchroniser, start-bit glitch rejection and framing-error detect;
  - internal loopback.
- Sits between the serial pins and any byte-level client (command parser, FIFO, test logic).

---
 rtl/uart_transceiver_param.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_transceiver_param.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transceiver_param.sv
// Parametrised full-duplex UART: ready/valid TX engine and an RX engine with a
// 2-FF synchroniser, start-bit glitch rejection, parity/framing checks and internal loopback.
module uart_transceiver_param #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_serial_out,
    input  logic                 i_serial_in,
    input  logic                 i_loopback,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_parity_error,
    output logic                 o_frame_error
);

    localparam int unsigned CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic HAS_PARITY = (PARITY_MODE != 0);
    localparam logic ODD_PARITY = (PARITY_MODE == 2);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_t;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh} rx_state_t;

    tx_state_t            r_tx_state;
    logic [CNT_W-1:0]     r_tx_cnt;
    logic [IDX_W-1:0]     r_tx_idx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_parity;
    logic                 r_tx_ready;
    logic                 r_serial_out;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_state   <= TxIdle;
            r_tx_cnt     <= '0;
            r_tx_idx     <= '0;
            r_tx_shift   <= '0;
            r_tx_parity  <= 1'b0;
            r_tx_ready   <= 1'b1;
            r_serial_out <= 1'b1;
        end else begin
            unique case (r_tx_state)
                TxIdle: begin
                    if (i_tx_valid && r_tx_ready) begin
                        r_tx_shift   <= i_tx_data;
                        r_tx_parity  <= ^i_tx_data ^ ODD_PARITY;
                        r_tx_cnt     <= '0;
                        r_tx_ready   <= 1'b0;
                        r_serial_out <= 1'b0;
                        r_tx_state   <= TxStart;
                    end
                end
                TxStart: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt     <= '0;
                        r_tx_idx     <= '0;
                        r_serial_out <= r_tx_shift[0];
                        r_tx_state   <= TxData;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TxData: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_idx == DATA_LAST) begin
                            if (HAS_PARITY) begin
                                r_serial_out <= r_tx_parity;
                                r_tx_state   <= TxParity;
                            end else begin
                                r_serial_out <= 1'b1;
                                r_tx_state   <= TxStop;
                            end
                        end else begin
                            r_tx_idx     <= r_tx_idx + 1'b1;
                            r_tx_shift   <= r_tx_shift >> 1;
                            r_serial_out <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TxParity: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt     <= '0;
                        r_serial_out <= 1'b1;
                        r_tx_state   <= TxStop;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TxStop: begin
                    // One counter run covers all stop bits.
                    if (r_tx_cnt == STOP_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_ready <= 1'b1;
                        r_tx_state <= TxIdle;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= TxIdle;
            endcase
        end
    end

    logic w_rx_line;
    logic r_sync1;
    logic r_sync2;

    assign w_rx_line = i_loopback ? r_serial_out : i_serial_in;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= w_rx_line;
            r_sync2 <= r_sync1;
        end
    end

    rx_state_t            r_rx_state;
    logic [CNT_W-1:0]     r_rx_cnt;
    logic [IDX_W-1:0]     r_rx_idx;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_bit;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_error;
    logic                 r_frame_error;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_state     <= RxIdle;
            r_rx_cnt       <= '0;
            r_rx_idx       <= '0;
            r_rx_shift     <= '0;
            r_rx_par_bit   <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            unique case (r_rx_state)
                RxIdle: begin
                    if (!r_sync2) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RxStart;
                    end
                end
                RxStart: begin
                    // Half-bit resample: a line back high means the start edge was a glitch.
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_idx <= '0;
                        r_rx_state <= r_sync2 ? RxIdle : RxData;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_sync2, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_idx == DATA_LAST) begin
                            r_rx_state <= HAS_PARITY ? RxParity : RxStop;
                        end else begin
                            r_rx_idx <= r_rx_idx + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RxParity: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt     <= '0;
                        r_rx_par_bit <= r_sync2;
                        r_rx_state   <= RxStop;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RxStop: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt       <= '0;
                        r_rx_valid     <= 1'b1;
                        r_rx_data      <= r_rx_shift;
                        r_parity_error <= HAS_PARITY & (^r_rx_shift ^ r_rx_par_bit ^ ODD_PARITY);
                        r_frame_error  <= ~r_sync2;
                        r_rx_state     <= r_sync2 ? RxIdle : RxWaitHigh;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RxWaitHigh: begin
                    if (r_sync2) begin
                        r_rx_state <= RxIdle;
                    end
                end
                default: r_rx_state <= RxIdle;
            endcase
        end
    end

    assign o_tx_ready     = r_tx_ready;
    assign o_serial_out   = r_serial_out;
    assign o_rx_data      = r_rx_data;
    assign o_rx_valid     = r_rx_valid;
    assign o_parity_error = r_parity_error;
    assign o_frame_error  = r_frame_error;

endmodule

// File: tb/tb_uart_transceiver_param.sv
// Bench for uart_transceiver_param: a frame-level TX/RX model checked every cycle,
// directed scenarios with literal expectations, then randomised frames.
module tb_uart_transceiver_param;

    localparam int C     = 8;
    localparam int D     = 8;
    localparam int FRAME = 11 * C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       serial_out;
    logic       serial_in;
    logic       loopback;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_error;
    logic       frame_error;

    uart_transceiver_param #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (D),
        .PARITY_MODE (1),
        .STOP_BITS   (1)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_serial_out  (serial_out),
        .i_serial_in   (serial_in),
        .i_loopback    (loopback),
        .o_rx_data     (rx_data),
        .o_rx_valid    (rx_valid),
        .o_parity_error(parity_error),
        .o_frame_error (frame_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a bit vector; each bit occupies C cycles of the line.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    int          m_tx_pos = 0;
    logic [10:0] m_frame  = '1;
    logic        m_raw    = 1'b1;
    int          m_cyc    = 0;
    logic        exp_txo;

    always_comb begin
        exp_txo = 1'b1;
        if (m_tx_pos != 0) exp_txo = m_frame[(m_tx_pos - 1) / C];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tx_pos <= 0;
            m_frame  <= '1;
            m_raw    <= 1'b1;
        end else begin
            m_raw <= loopback ? exp_txo : serial_in;
            m_cyc <= m_cyc + 1;
            if (m_tx_pos == 0) begin
                if (tx_valid) begin
                    m_frame  <= frame_of(tx_data);
                    m_tx_pos <= 1;
                end
            end else begin
                m_tx_pos <= (m_tx_pos == FRAME) ? 0 : m_tx_pos + 1;
            end
        end
    end

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_exp_t;

    rx_exp_t exp_q[$];

    // Receiver model: sample the raw line at mid-bit from the detected fall; result
    // appears two cycles (synchroniser) after the stop sample.
    initial begin : rx_model
        logic [7:0] sh;
        logic       pb;
        logic       sb;
        forever begin
            @(negedge clk);
            if (m_raw == 1'b0) begin
                repeat (C / 2) @(negedge clk);
                if (m_raw == 1'b0) begin
                    for (int k = 0; k < D; k++) begin
                        repeat (C) @(negedge clk);
                        sh[k] = m_raw;
                    end
                    repeat (C) @(negedge clk);
                    pb = m_raw;
                    repeat (C) @(negedge clk);
                    sb = m_raw;
                    exp_q.push_back('{cyc: m_cyc + 2, data: sh, perr: ((^sh) != pb), ferr: !sb});
                    if (!sb) begin
                        do @(negedge clk); while (m_raw == 1'b0);
                    end
                end
            end
        end
    end

    rx_exp_t    e;
    logic       ev;
    logic [7:0] hd = '0;
    logic       hp = 1'b0;
    logic       hf = 1'b0;

    always @(negedge clk) begin
        ev = 1'b0;
        if (!rst_n) begin
            hd = '0;
            hp = 1'b0;
            hf = 1'b0;
            exp_q.delete();
        end else if (exp_q.size() > 0 && exp_q[0].cyc == m_cyc) begin
            e  = exp_q.pop_front();
            ev = 1'b1;
            hd = e.data;
            hp = e.perr;
            hf = e.ferr;
        end
        check("serial_out", 32'(serial_out), 32'(exp_txo));
        check("tx_ready", 32'(tx_ready), 32'(m_tx_pos == 0));
        check("rx_valid", 32'(rx_valid), 32'(ev));
        check("rx_data", 32'(rx_data), 32'(hd));
        check("parity_error", 32'(parity_error), 32'(hp));
        check("frame_error", 32'(frame_error), 32'(hf));
    end

    task automatic send_serial(input logic [7:0] d, input logic pbit, input logic sbit,
                               input int tail_low);
        logic [10:0] f;
        f = {sbit, pbit, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            serial_in = f[i];
            repeat (C) @(negedge clk);
        end
        if (tail_low > 0) begin
            serial_in = 1'b0;
            repeat (tail_low) @(negedge clk);
        end
        serial_in = 1'b1;
    endtask

    task automatic wait_valid(input int max, output logic [7:0] d, output logic pe,
                              output logic fe);
        int n;
        n = 0;
        while (!rx_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!rx_valid) begin
            total++;
            bad++;
            $display("FAIL wait_rx_valid: no pulse within %0d cycles", max);
        end
        d  = rx_data;
        pe = parity_error;
        fe = frame_error;
        @(negedge clk);
    endtask

    logic [7:0]  d;
    logic        pe;
    logic        fe;
    logic [10:0] bits;
    logic [7:0]  rd;
    logic        pb;
    logic        sb;
    int          n;
    int          nv;
    int          hi;
    int          lowcnt;
    int          tl;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = '0;
        serial_in = 1'b1;
        loopback  = 1'b0;
        #1 rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_serial_out", 32'(serial_out), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5: sample every bit at mid-bit and time the busy window.
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        bits     = '0;
        lowcnt   = 0;
        for (int i = 0; i < 200 && !tx_ready; i++) begin
            if (i % C == C / 2 && i / C < 11) bits[i / C] = serial_out;
            lowcnt++;
            tx_data = 8'($urandom);
            @(negedge clk);
        end
        check("a5_bits", 32'(bits), 32'(11'b10101001010));
        check("a5_ready_low", 32'(lowcnt), 32'(FRAME));
        repeat (4) @(negedge clk);

        // Asynchronous reset while 0x5A is driving a 0 data bit.
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (30) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_serial_out", 32'(serial_out), 32'd1);
        check("arst_tx_ready", 32'(tx_ready), 32'd1);
        check("arst_rx_valid", 32'(rx_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Loopback 0x3C.
        loopback = 1'b1;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_valid(200, d, pe, fe);
        check("lb_data", 32'(d), 32'h3C);
        check("lb_perr", 32'(pe), 32'd0);
        check("lb_ferr", 32'(fe), 32'd0);
        repeat (40) @(negedge clk);
        loopback = 1'b0;
        repeat (4) @(negedge clk);

        // 0x81 with a wrong (odd) parity bit.
        fork
            send_serial(8'h81, 1'b1, 1'b1, 0);
            wait_valid(200, d, pe, fe);
        join
        check("par_data", 32'(d), 32'h81);
        check("par_perr", 32'(pe), 32'd1);
        check("par_ferr", 32'(fe), 32'd0);
        repeat (10) @(negedge clk);

        // 0x55 with stop bit 0 and the line held low, then a clean 0x0F.
        nv = 0;
        fork
            send_serial(8'h55, 1'b0, 1'b0, 40);
            begin
                wait_valid(200, d, pe, fe);
                repeat (50) begin
                    if (rx_valid) nv++;
                    @(negedge clk);
                end
            end
        join
        check("fe_data", 32'(d), 32'h55);
        check("fe_perr", 32'(pe), 32'd0);
        check("fe_ferr", 32'(fe), 32'd1);
        check("fe_no_extra_valid", 32'(nv), 32'd0);
        repeat (10) @(negedge clk);
        fork
            send_serial(8'h0F, 1'b0, 1'b1, 0);
            wait_valid(200, d, pe, fe);
        join
        check("good_data", 32'(d), 32'h0F);
        check("good_perr", 32'(pe), 32'd0);
        check("good_ferr", 32'(fe), 32'd0);
        repeat (10) @(negedge clk);

        // Two-cycle low glitch must not produce a word.
        serial_in = 1'b0;
        repeat (2) @(negedge clk);
        serial_in = 1'b1;
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (rx_valid) n++;
        end
        check("glitch_no_valid", 32'(n), 32'd0);

        // Back-to-back frames with tx_valid held high.
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h22;
        n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        while (tx_ready && hi < 5) begin
            hi++;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("b2b_idle_gap", 32'(hi), 32'd1);
        repeat (FRAME + 10) @(negedge clk);

        // Random serial frames on the RX pin, concurrent with random TX words.
        for (int it = 0; it < 10; it++) begin
            rd = 8'($urandom);
            pb = (^rd) ^ ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 4) != 0);
            tl = sb ? 0 : int'($urandom_range(0, 20));
            fork
                send_serial(rd, pb, sb, tl);
                begin
                    tx_data  = 8'($urandom);
                    tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                    repeat (FRAME + 2) begin
                        tx_data = 8'($urandom);
                        @(negedge clk);
                    end
                end
            join
            repeat (20) @(negedge clk);
            serial_in = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            serial_in = 1'b1;
            repeat (20) @(negedge clk);
        end

        // Random loopback words.
        loopback = 1'b1;
        for (int it = 0; it < 5; it++) begin
            tx_data  = 8'($urandom);
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (FRAME + 20) @(negedge clk);
        end
        loopback = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
